// File: rtl/cpu_bus_if_if.sv
// System-bus handshake signals between the CPU access block (master) and the bus (slave).
interface cpu_bus_if_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              bus_req_;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_as_;
  logic              bus_rw;
  logic [DATA_W-1:0] bus_wr_data;
  logic [DATA_W-1:0] bus_rd_data;
  logic              bus_rdy_;
  logic              bus_grnt_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_rd_data, bus_rdy_, bus_grnt_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_rd_data, bus_rdy_, bus_grnt_
  );
endinterface

// File: rtl/cpu_bus_if.sv
// CPU memory access interface: same-cycle scratch-pad accesses, req/grant/ready system-bus accesses.
// Optional bus timeout with bus_err output is enabled by defining BUS_IF_TIMEOUT_EN.
module cpu_bus_if #(
  parameter int unsigned ADDR_W        = 30,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned SPM_ADDR_W    = 12,
  parameter logic [2:0]  SPM_SLAVE_IDX = 3'd1
`ifdef BUS_IF_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC   = 255
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  busy,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  as_,
  input  logic                  rw,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [DATA_W-1:0]     spm_rd_data,
  output logic [SPM_ADDR_W-1:0] spm_addr,
  output logic                  spm_as_,
  output logic                  spm_rw,
  output logic [DATA_W-1:0]     spm_wr_data,
`ifdef BUS_IF_TIMEOUT_EN
  output logic                  bus_err,
`endif
  cpu_bus_if_if.master          bus
);

  localparam logic READ  = 1'b1;
`ifdef BUS_IF_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    STALL  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_as_q, bus_as_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic              bus_rw_q, bus_rw_d;
  logic [DATA_W-1:0] bus_wr_data_q, bus_wr_data_d;
  logic [DATA_W-1:0] rd_buf_q, rd_buf_d;
  logic              spm_hit;
`ifdef BUS_IF_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  assign spm_hit     = (addr[ADDR_W-1 -: 3] == SPM_SLAVE_IDX);
  assign spm_addr    = addr[SPM_ADDR_W-1:0];
  assign spm_rw      = rw;
  assign spm_wr_data = wr_data;

  assign bus.bus_req_    = bus_req_q;
  assign bus.bus_as_     = bus_as_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_rw      = bus_rw_q;
  assign bus.bus_wr_data = bus_wr_data_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      bus_req_q     <= 1'b1;
      bus_as_q      <= 1'b1;
      bus_addr_q    <= '0;
      bus_rw_q      <= READ;
      bus_wr_data_q <= '0;
      rd_buf_q      <= '0;
`ifdef BUS_IF_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bus_req_q     <= bus_req_d;
      bus_as_q      <= bus_as_d;
      bus_addr_q    <= bus_addr_d;
      bus_rw_q      <= bus_rw_d;
      bus_wr_data_q <= bus_wr_data_d;
      rd_buf_q      <= rd_buf_d;
`ifdef BUS_IF_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_addr_d    = bus_addr_q;
    bus_rw_d      = bus_rw_q;
    bus_wr_data_d = bus_wr_data_q;
    rd_buf_d      = rd_buf_q;
    rd_data       = '0;
    spm_as_       = 1'b1;
    busy          = 1'b0;
`ifdef BUS_IF_TIMEOUT_EN
    cnt_d         = cnt_q;
    bus_err       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!flush && !as_) begin
          if (spm_hit) begin
            if (!stall) begin
              spm_as_ = 1'b0;
              if (rw == READ) rd_data = spm_rd_data;
            end
          end else begin
            busy          = 1'b1;
            state_d       = REQ;
            bus_req_d     = 1'b0;
            bus_addr_d    = addr;
            bus_rw_d      = rw;
            bus_wr_data_d = wr_data;
`ifdef BUS_IF_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end
        end
      end

      REQ: begin
        busy = 1'b1;
        if (!bus.bus_grnt_) begin
          state_d  = ACCESS;
          bus_as_d = 1'b0;
        end
      end

      ACCESS: begin
        bus_as_d = 1'b1;
        if (!bus.bus_rdy_) begin
          if (bus_rw_q == READ) rd_data = bus.bus_rd_data;
          // Writes leave zero in the buffer so a stalled write returns no data.
          rd_buf_d      = (bus_rw_q == READ) ? bus.bus_rd_data : '0;
          bus_req_d     = 1'b1;
          bus_addr_d    = '0;
          bus_rw_d      = READ;
          bus_wr_data_d = '0;
          state_d       = stall ? STALL : IDLE;
        end else begin
          busy = 1'b1;
        end
      end

      STALL: begin
        if (bus_rw_q == READ) rd_data = rd_buf_q;
        if (!stall) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef BUS_IF_TIMEOUT_EN
    // Abandon a bus access that neither completes nor gets granted in time.
    if (state_q == REQ || (state_q == ACCESS && bus.bus_rdy_)) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
        bus_err       = 1'b1;
        busy          = 1'b0;
        rd_data       = '0;
        rd_buf_d      = '0;
        bus_req_d     = 1'b1;
        bus_as_d      = 1'b1;
        bus_addr_d    = '0;
        bus_rw_d      = READ;
        bus_wr_data_d = '0;
        state_d       = stall ? STALL : IDLE;
      end
    end
`endif
  end

endmodule

// File: tb/tb_cpu_bus_if.sv
// Directed bench for cpu_bus_if: per-cycle vector table plus a long grant-wait sequence.
module tb_cpu_bus_if;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        busy;
  logic [29:0] addr;
  logic        as_;
  logic        rw;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [31:0] spm_rd_data;
  logic [11:0] spm_addr;
  logic        spm_as_;
  logic        spm_rw;
  logic [31:0] spm_wr_data;
`ifdef BUS_IF_TIMEOUT_EN
  logic        bus_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cpu_bus_if_if #(.ADDR_W(30), .DATA_W(32)) bus_if ();

  cpu_bus_if dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .busy        (busy),
    .addr        (addr),
    .as_         (as_),
    .rw          (rw),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .spm_rd_data (spm_rd_data),
    .spm_addr    (spm_addr),
    .spm_as_     (spm_as_),
    .spm_rw      (spm_rw),
    .spm_wr_data (spm_wr_data),
`ifdef BUS_IF_TIMEOUT_EN
    .bus_err     (bus_err),
`endif
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n, stall, flush, as_n, rw, rdy_n, grnt_n;
    logic [29:0] addr;
    logic [31:0] wdata, bus_rd;
    logic        e_busy;
    logic [31:0] e_rd;
    logic        e_spm_as_n;
    logic [11:0] e_spm_addr;
    logic        e_req_n, e_as_n;
    logic [29:0] e_baddr;
    logic        e_brw;
    logic [31:0] e_bwd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_n, stall_i, flush_i, as_n, rw_i, rdy_n, grnt_n,
                              input logic [29:0] a, input logic [31:0] wd, brd,
                              input logic e_busy, input logic [31:0] e_rd, input logic e_spm_as_n,
                              input logic e_req_n, e_as_n, input logic [29:0] e_baddr,
                              input logic e_brw, input logic [31:0] e_bwd);
    vec_t v;
    v.rst_n = rst_n; v.stall = stall_i; v.flush = flush_i; v.as_n = as_n; v.rw = rw_i;
    v.rdy_n = rdy_n; v.grnt_n = grnt_n; v.addr = a; v.wdata = wd; v.bus_rd = brd;
    v.e_busy = e_busy; v.e_rd = e_rd; v.e_spm_as_n = e_spm_as_n; v.e_spm_addr = a[11:0];
    v.e_req_n = e_req_n; v.e_as_n = e_as_n; v.e_baddr = e_baddr; v.e_brw = e_brw; v.e_bwd = e_bwd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  localparam logic [29:0] S = 30'h0800_0005;

  initial begin
    logic found;
    reset = 1'b0; stall = 1'b0; flush = 1'b0; as_ = 1'b1; rw = 1'b1;
    addr = '0; wr_data = '0; spm_rd_data = 32'h99;
    bus_if.bus_rd_data = 32'h98; bus_if.bus_rdy_ = 1'b1; bus_if.bus_grnt_ = 1'b0;

    //                rst st fl as rw rdy gnt addr   wdata   bus_rd    busy rd       spm req bas baddr rw wdata
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h1, 32'h0,  32'h98,   1, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h1, 32'h0,  32'h98,   1, 32'h0,  1, 0, 1, 30'h1, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h1, 32'h0,  32'h98,   1, 32'h0,  1, 0, 0, 30'h1, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 30'h1, 32'h0,  32'h98,   0, 32'h98, 1, 0, 1, 30'h1, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, S,     32'h0,  32'h98,   0, 32'h99, 0, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, S,     32'hA5, 32'h98,   0, 32'h0,  0, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, S,     32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 30'h2, 32'h97, 32'h98,   1, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 1, 1, 30'h2, 32'h97, 32'h98,   1, 32'h0,  1, 0, 1, 30'h2, 0, 32'h97));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 30'h2, 32'h97, 32'h98,   1, 32'h0,  1, 0, 1, 30'h2, 0, 32'h97));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 30'h2, 32'h97, 32'h98,   1, 32'h0,  1, 0, 0, 30'h2, 0, 32'h97));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 30'h2, 32'h97, 32'h98,   0, 32'h0,  1, 0, 1, 30'h2, 0, 32'h97));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h3, 32'h0,  32'h98,   1, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h3, 32'h0,  32'h98,   1, 32'h0,  1, 0, 1, 30'h3, 1, 32'h0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 0, 0, 30'h3, 32'h0,  32'h98,   0, 32'h98, 1, 0, 0, 30'h3, 1, 32'h0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h55,   0, 32'h98, 1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h55,   0, 32'h98, 1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, 30'h4, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 1, 0, S,     32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 30'h5, 32'h0,  32'h98,   1, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 30'h5, 32'h0,  32'h98,   1, 32'h0,  1, 0, 1, 30'h5, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 1, 30'h0, 32'h0,  32'h98,   0, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h6, 32'h0,  32'h98,   1, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h6, 32'h0,  32'h98,   1, 32'h0,  1, 0, 1, 30'h6, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 30'h6, 32'h0,  32'h98,   0, 32'h98, 1, 0, 0, 30'h6, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h6, 32'h0,  32'h98,   1, 32'h0,  1, 1, 1, 30'h0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 30'h6, 32'h0,  32'h98,   1, 32'h0,  1, 0, 1, 30'h6, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 30'h0, 32'h0,  32'h98,   1, 32'h0,  1, 0, 0, 30'h6, 1, 32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].rst_n; stall = vecs[i].stall; flush = vecs[i].flush;
      as_ = vecs[i].as_n; rw = vecs[i].rw; addr = vecs[i].addr; wr_data = vecs[i].wdata;
      bus_if.bus_rdy_ = vecs[i].rdy_n; bus_if.bus_grnt_ = vecs[i].grnt_n;
      bus_if.bus_rd_data = vecs[i].bus_rd;
      #1;
      chk($sformatf("row%0d_busy", i),      32'(busy),               32'(vecs[i].e_busy));
      chk($sformatf("row%0d_rd_data", i),   rd_data,                 vecs[i].e_rd);
      chk($sformatf("row%0d_spm_as_", i),   32'(spm_as_),            32'(vecs[i].e_spm_as_n));
      chk($sformatf("row%0d_spm_addr", i),  32'(spm_addr),           32'(vecs[i].e_spm_addr));
      chk($sformatf("row%0d_spm_rw", i),    32'(spm_rw),             32'(vecs[i].rw));
      chk($sformatf("row%0d_spm_wdata", i), spm_wr_data,             vecs[i].wdata);
      chk($sformatf("row%0d_bus_req_", i),  32'(bus_if.bus_req_),    32'(vecs[i].e_req_n));
      chk($sformatf("row%0d_bus_as_", i),   32'(bus_if.bus_as_),     32'(vecs[i].e_as_n));
      chk($sformatf("row%0d_bus_addr", i),  32'(bus_if.bus_addr),    32'(vecs[i].e_baddr));
      chk($sformatf("row%0d_bus_rw", i),    32'(bus_if.bus_rw),      32'(vecs[i].e_brw));
      chk($sformatf("row%0d_bus_wdata", i), bus_if.bus_wr_data,      vecs[i].e_bwd);
    end

    // Long grant wait: busy and request must hold, strobe must stay idle until grant.
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; addr = 30'h7; as_ = 1'b0; rw = 1'b1;
    bus_if.bus_grnt_ = 1'b1; bus_if.bus_rdy_ = 1'b1;
    #1;
    chk("gw_start_busy", 32'(busy), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      chk($sformatf("gw%0d_busy", c),     32'(busy),            32'd1);
      chk($sformatf("gw%0d_bus_req_", c), 32'(bus_if.bus_req_), 32'd0);
      chk($sformatf("gw%0d_bus_as_", c),  32'(bus_if.bus_as_),  32'd1);
    end
    bus_if.bus_grnt_ = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk); #1;
      if (bus_if.bus_as_ === 1'b0) found = 1'b1;
    end
    chk("gw_strobe_seen", 32'(found), 32'd1);
    bus_if.bus_rdy_ = 1'b0; bus_if.bus_rd_data = 32'h1234_5678;
    #1;
    chk("gw_rdy_busy",    32'(busy), 32'd0);
    chk("gw_rdy_rd_data", rd_data,   32'h1234_5678);
    @(negedge clk);
    bus_if.bus_rdy_ = 1'b1; as_ = 1'b1;
    #1;
    chk("gw_rel_bus_req_", 32'(bus_if.bus_req_), 32'd1);
    chk("gw_rel_bus_as_",  32'(bus_if.bus_as_),  32'd1);
    chk("gw_rel_bus_addr", 32'(bus_if.bus_addr), 32'd0);
    chk("gw_rel_rd_data",  rd_data,              32'd0);
    chk("gw_rel_busy",     32'(busy),            32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_bus_if.md
Name: cpu_bus_if

Overview:
- CPU-side memory access interface used by the fetch and memory stages.
- Takes one word-addressed request per cycle from the pipeline.
- Requests to the scratch-pad memory (SPM) complete combinationally in the same cycle.
- All other requests go through a request/grant/ready handshake on the shared system bus. The block holds the pipeline via `busy` until the bus access completes.

Parameters:
- ADDR_W, 30, word address width (addr, bus_addr).
- DATA_W, 32, data word width.
- SPM_ADDR_W, 12, SPM word address width; spm_addr = addr[SPM_ADDR_W-1:0].
- SPM_SLAVE_IDX, 3'd1, value of addr[ADDR_W-1:ADDR_W-3] that selects the SPM.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-low reset (0 = reset).
- stall  in  1  pipeline stall, active-high.
- flush  in  1  pipeline flush, active-high; suppresses a new access.
- busy  out  1  active-high; the external access is not finished.
- addr  in  ADDR_W  word address.
- as_  in  1  address strobe, active-low.
- rw  in  1  1 = READ, 0 = WRITE.
- wr_data  in  DATA_W  write data.
- rd_data  out  DATA_W  read data to the pipeline.
- spm_rd_data  in  DATA_W  SPM read data.
- spm_addr  out  SPM_ADDR_W  SPM address.
- spm_as_  out  1  SPM strobe, active-low.
- spm_rw  out  1  SPM read/write; driven directly from rw.
- spm_wr_data  out  DATA_W  SPM write data; driven directly from wr_data.
- bus_rd_data  in  DATA_W  bus read data.
- bus_rdy_  in  1  bus ready, active-low.
- bus_grnt_  in  1  bus grant, active-low.
- bus_req_  out  1  bus request, active-low (registered).
- bus_addr  out  ADDR_W  bus address (registered).
- bus_as_  out  1  bus strobe, active-low (registered).
- bus_rw  out  1  bus read/write (registered).
- bus_wr_data  out  DATA_W  bus write data (registered).

Behaviour:
- spm_hit = (addr[ADDR_W-1:ADDR_W-3] == SPM_SLAVE_IDX).
- States: IDLE, REQ, ACCESS, STALL.
- Reset (reset=0 at a clock edge):
  - state = IDLE, bus_req_ = 1, bus_as_ = 1, bus_addr = 0, bus_rw = READ, bus_wr_data = 0, rd_buf = 0.
- Combinational defaults: rd_data = 0, spm_as_ = 1, busy = 0.
- IDLE, when !flush and as_ = 0:
  - On an SPM hit with !stall: spm_as_ = 0; if rw = READ, rd_data = spm_rd_data (0-cycle latency).
  - On an SPM hit with stall: spm_as_ stays 1 and no access occurs.
  - On a non-SPM request: busy = 1.
- REQ: busy = 1.
- ACCESS:
  - If bus_rdy_ = 0: busy = 0; if bus_rw = READ, rd_data = bus_rd_data.
  - Otherwise busy = 1.
- STALL: if bus_rw = READ, rd_data = rd_buf; busy = 0.
- Transitions:
  - IDLE to REQ when !flush, as_ = 0 and !spm_hit. On that edge: bus_req_ = 0, bus_addr = addr, bus_rw = rw, bus_wr_data = wr_data.
  - REQ to ACCESS when bus_grnt_ = 0; set bus_as_ = 0. Otherwise remain in REQ.
  - ACCESS: bus_as_ returns to 1 after one cycle, so the strobe is a single-cycle pulse.
  - ACCESS, when bus_rdy_ = 0: bus_req_ = 1, bus_addr = 0, bus_rw = READ, bus_wr_data = 0. On a read, rd_buf = bus_rd_data. Next state is STALL if stall = 1, else IDLE.
  - ACCESS, when bus_rdy_ = 1: remain in ACCESS.
  - STALL to IDLE when stall = 0.
- Boundary conditions:
  - flush is only honoured in IDLE; once a bus access has started it always runs to completion.
  - stall has no effect in REQ or ACCESS.
  - If as_ is still 0 when the block returns to IDLE, a new access starts on the next cycle.
  - Reset in any state aborts the transaction immediately and restores the reset values.
  - Write accesses return rd_data = 0.

Optional Feature:
- Macro: BUS_IF_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT_CYC (default 255) and output port bus_err (1 bit, active-high).
  - An 8-bit-or-wider counter clears on entry to REQ and counts every cycle spent in REQ or ACCESS.
  - When the counter reaches TIMEOUT_CYC without bus_rdy_ = 0, the block releases the bus exactly as on ready (bus_req_ = 1, bus_as_ = 1, bus_addr = 0, bus_rw = READ, bus_wr_data = 0).
  - On timeout it pulses bus_err = 1 for one cycle, drives busy = 0, and returns rd_data = 0 for that cycle. It then goes to IDLE, or to STALL with rd_buf = 0 if stall = 1.
- When not defined: no counter, no bus_err port, and the block waits indefinitely.

Test Plan:
- Reset: hold reset=0 for one edge → bus_req_=1, bus_as_=1, bus_addr=0, bus_rw=1, bus_wr_data=0, busy=0, rd_data=0.
- External read, grant already asserted:
  - Stimulus: addr=30'h1, as_=0, rw=READ, bus_grnt_=0, bus_rd_data=32'h98, spm_rd_data=32'h99, bus_rdy_=1.
  - Cycle 0: busy=1.
  - Edge 1: bus_req_=0, bus_addr=1.
  - Edge 2: bus_as_=0.
  - Drop bus_rdy_ to 0 → same cycle busy=0, rd_data=32'h98.
  - Next edge: bus_req_=1, bus_addr=0.
- SPM read: addr=30'h0800_0005, as_=0, rw=READ, spm_rd_data=32'h99 → same cycle spm_as_=0, spm_addr=12'h005, rd_data=32'h99, busy=0; bus_req_ stays 1.
- External write: addr=30'h2, rw=WRITE, wr_data=32'h97 → registered bus_rw=0, bus_wr_data=32'h97; on ready, rd_data=0.
- Stall at completion: stall=1 when bus_rdy_=0 on a read of 32'h98 → STALL, rd_data=32'h98 held, busy=0. Release stall → IDLE.
- Flush: flush=1, as_=0, non-SPM addr → busy=0, bus_req_ stays 1; with an SPM addr, spm_as_ stays 1.
